// File: rtl/m_div_pkg.sv
// Shared encodings for the M-extension restoring divider: mux selects, opcodes and FSM states.
// Used by the division controller and the R/D/Z register bank.
package m_div_pkg;

    localparam int unsigned MUX_R_W = 2;
    localparam int unsigned MUX_D_W = 2;
    localparam int unsigned MUX_Z_W = 2;

    localparam logic [MUX_R_W-1:0] MUX_R_KEEP     = 2'd0;
    localparam logic [MUX_R_W-1:0] MUX_R_A        = 2'd1;
    localparam logic [MUX_R_W-1:0] MUX_R_A_NEG    = 2'd2;
    localparam logic [MUX_R_W-1:0] MUX_R_SUB_KEEP = 2'd3;

    localparam logic [MUX_D_W-1:0] MUX_D_KEEP  = 2'd0;
    localparam logic [MUX_D_W-1:0] MUX_D_B     = 2'd1;
    localparam logic [MUX_D_W-1:0] MUX_D_B_NEG = 2'd2;
    localparam logic [MUX_D_W-1:0] MUX_D_SHR   = 2'd3;

    localparam logic [MUX_Z_W-1:0] MUX_Z_KEEP    = 2'd0;
    localparam logic [MUX_Z_W-1:0] MUX_Z_ZERO    = 2'd1;
    localparam logic [MUX_Z_W-1:0] MUX_Z_SHL_ADD = 2'd2;

    // bit0 = unsigned, bit1 = remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StInit = 2'd1,
        StIter = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/m_div_controller.sv
// Sequencing FSM for the restoring divider: load, ITERATIONS shift/subtract steps, result handshake.
// Optional macro M_DIV_ZERO_BYPASS_EN skips the iterations when the divisor is zero.
module m_div_controller
    import m_div_pkg::*;
#(
    parameter int unsigned ITERATIONS = 32,
    parameter int unsigned CNT_W      = $clog2(ITERATIONS + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_op,
    input  logic               i_rs1_msb,
    input  logic               i_rs2_msb,
    input  logic               i_rs2_is_zero,
    input  logic               i_flush,
    input  logic               i_result_ready,
    output logic [MUX_R_W-1:0] o_mux_r,
    output logic [MUX_D_W-1:0] o_mux_d,
    output logic [MUX_Z_W-1:0] o_mux_z,
    output logic               o_busy,
    output logic               o_result_valid,
    output logic               o_result_sel_rem,
    output logic               o_result_negate,
    output logic               o_result_dz
);

    div_state_e       r_state;
    div_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_rs1_msb;
    logic             r_rs2_msb;
    logic             r_rs2_zero;
    logic             r_valid;
    logic             r_sel_rem;
    logic             r_negate;
    logic             r_dz;
    logic             w_latch;
    logic             w_signed;
    logic             w_done_entry;

    assign w_signed     = ~r_op[0];
    assign w_done_entry = (w_state_d == StDone) && (r_state != StDone);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_latch   = 1'b0;
        if (i_flush) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_d = StInit;
                        w_latch   = 1'b1;
                    end
                end
                StInit: begin
`ifdef M_DIV_ZERO_BYPASS_EN
                    w_state_d = r_rs2_zero ? StDone : StIter;
`else
                    w_state_d = StIter;
`endif
                end
                StIter: begin
                    if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
                        w_state_d = StDone;
                    end
                end
                StDone: begin
                    // A new request may ride on the same cycle as the result handshake.
                    if (i_result_ready) begin
                        w_state_d = i_start ? StInit : StIdle;
                        w_latch   = i_start;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        o_mux_r = MUX_R_KEEP;
        o_mux_d = MUX_D_KEEP;
        o_mux_z = MUX_Z_KEEP;
        case (r_state)
            StInit: begin
                o_mux_r = (w_signed && r_rs1_msb) ? MUX_R_A_NEG : MUX_R_A;
                o_mux_d = (w_signed && r_rs2_msb) ? MUX_D_B_NEG : MUX_D_B;
                o_mux_z = MUX_Z_ZERO;
            end
            StIter: begin
                o_mux_r = MUX_R_SUB_KEEP;
                o_mux_d = MUX_D_SHR;
                o_mux_z = MUX_Z_SHL_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (r_state == StInit) begin
            r_cnt <= '0;
        end else if (r_state == StIter) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op       <= 2'b00;
            r_rs1_msb  <= 1'b0;
            r_rs2_msb  <= 1'b0;
            r_rs2_zero <= 1'b0;
        end else if (w_latch) begin
            r_op       <= i_op;
            r_rs1_msb  <= i_rs1_msb;
            r_rs2_msb  <= i_rs2_msb;
            r_rs2_zero <= i_rs2_is_zero;
        end
    end

    // Result controls are captured on DONE entry so they stay frozen under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_negate  <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_valid <= (w_state_d == StDone);
            if (w_done_entry) begin
                r_sel_rem <= r_op[1];
                r_negate  <= w_signed & (r_op[1] ? r_rs1_msb
                                                 : ((r_rs1_msb ^ r_rs2_msb) & ~r_rs2_zero));
                r_dz      <= r_rs2_zero & ~r_op[1];
            end
        end
    end

    assign o_busy           = (r_state != StIdle);
    assign o_result_valid   = r_valid;
    assign o_result_sel_rem = r_sel_rem;
    assign o_result_negate  = r_negate;
    assign o_result_dz      = r_dz;

endmodule

// File: doc/m_div_controller.md
Name: m_div_controller

Overview:
- FSM that sequences the M-extension restoring-division datapath (R/D/Z register bank).
- Drives the bank's mux selects: load, per-iteration compare/shift, hold.
- Tracks operand signs and opcode; emits result-select and sign-fix controls.
- Sits between the M-unit issue logic and the division register bank; valid/ready handshake on the result side.

Parameters:
- ITERATIONS, 32, number of shift/subtract iterations.
- CNT_W, $clog2(ITERATIONS+1), iteration counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  request; accepted only when busy=0
- op  in  2  bit0=unsigned, bit1=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- rs1_msb  in  1  dividend sign bit
- rs2_msb  in  1  divisor sign bit
- rs2_is_zero  in  1  divisor equals zero
- flush  in  1  synchronous abort
- result_ready  in  1  consumer accepts result
- mux_r  out  MUX_R_W  remainder-register select
- mux_d  out  MUX_D_W  divisor-register select
- mux_z  out  MUX_Z_W  quotient-register select
- busy  out  1  operation in flight (state != IDLE)
- result_valid  out  1  result available
- result_sel_rem  out  1  1=output R, 0=output Z
- result_negate  out  1  downstream two's-complement of selected value
- result_dz  out  1  divide-by-zero force; quotient output is all-ones

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, all latched operand info=0, mux_* = KEEP, busy=0, result_valid=0, result_sel_rem=0, result_negate=0, result_dz=0.
- State IDLE:
  - mux_* = KEEP.
  - start=1 latches op, rs1_msb, rs2_msb, rs2_is_zero, then goes to INIT.
- State INIT (1 cycle):
  - mux_r = A_NEG if signed & rs1_msb, else A.
  - mux_d = B_NEG if signed & rs2_msb, else B.
  - mux_z = ZERO. counter <= 0.
  - Next state: ITER.
- State ITER:
  - mux_r = SUB_KEEP, mux_d = SHR, mux_z = SHL_ADD. counter increments each cycle.
  - Exactly ITERATIONS cycles, then DONE.
- State DONE:
  - mux_* = KEEP; result_valid=1.
  - Outputs stable until result_ready=1.
  - On handshake: go to IDLE. If start=1 in the same cycle, latch the new operands and go directly to INIT.
- Latency: start accepted at edge t → INIT during cycle t+1, ITER cycles t+2..t+33, result_valid first high at cycle t+34.
- Sign rules (from latched values):
  - result_sel_rem = op[1].
  - Quotient: result_negate = !op[0] & (rs1_msb ^ rs2_msb) & !rs2_is_zero.
  - Remainder: result_negate = !op[0] & rs1_msb.
  - Unsigned ops: result_negate = 0.
- Divide by zero:
  - Quotient is never negated.
  - result_dz = rs2_is_zero & !op[1].
  - Remainder naturally equals rs1.
- Overflow (-2^31 / -1): no special case; 32-bit wrap gives quotient 0x80000000, remainder 0.
- start while busy: ignored. No queuing.
- flush: highest priority after reset, in any state.
  - Next cycle: state=IDLE, mux_*=KEEP, result_valid=0.
  - A pending result is discarded.
- Reset mid-operation: identical to flush, plus all latched info cleared.
- result_valid and result_* outputs are registered. mux_* are combinational from state only.

Optional Feature:
- Macro: M_DIV_ZERO_BYPASS_EN
- Defined: if latched rs2_is_zero=1, INIT transitions directly to DONE (ITER skipped); result_valid at t+2. result_dz asserted as above.
- Undefined: full ITERATIONS always run; result_dz still generated per Behaviour rules; timing always t+34.

Decomposition:
- Package m_div_pkg holds:
  - MUX_R_W/MUX_D_W = 2, MUX_Z_W = 2.
  - Codes MUX_R_{KEEP,A,A_NEG,SUB_KEEP}, MUX_D_{KEEP,B,B_NEG,SHR}, MUX_Z_{KEEP,ZERO,SHL_ADD}.
  - Op encodings.
  - State enum {IDLE, INIT, ITER, DONE}.
- The register bank imports the same package.
- No sub-module: counter and FSM fit in one module.

Test Plan:
- DIVU op=01, rs1_msb=0, rs2_msb=0, start at t:
  - INIT at t+1 shows mux_r=A, mux_d=B, mux_z=ZERO.
  - Exactly 32 ITER cycles.
  - result_valid at t+34, sel_rem=0, negate=0.
- DIV -7/2 (op=00, rs1_msb=1, rs2_msb=0):
  - INIT shows mux_r=A_NEG, mux_d=B.
  - At DONE: result_negate=1, sel_rem=0.
- REM -7/2 (op=10, rs1_msb=1) → sel_rem=1, negate=1. REMU with same signs → negate=0.
- DIV 5/0 (rs2_is_zero=1):
  - Quotient: negate=0, result_dz=1.
  - With M_DIV_ZERO_BYPASS_EN: valid at t+2. Without: valid at t+34.
- Backpressure: hold result_ready=0 for 5 cycles in DONE → valid and controls stable, mux_*=KEEP, start ignored. Ready+start together → INIT next cycle.
- flush at 10th ITER cycle → IDLE next cycle, busy=0, valid never asserted. Repeat with reset → all outputs at reset values.
